// File: rtl/bin2ascii.sv
`default_nettype none
// ============================================================================
// Module      : bin2ascii
// Description : Converts one unsigned binary value into a fixed-width stream
//               of ASCII decimal characters, most significant digit first,
//               one byte per dout valid/ready handshake. Conversion is a
//               serial double-dabble (shift-add-3), one input bit per clock.
// Ports       : clk         - clock, all logic on rising edge
//               rst_n       - asynchronous reset, active low
//               din         - unsigned binary value (W bits)
//               din_valid   - din qualifier
//               din_ready   - high only while idle; value taken on valid&ready
//               dout        - ASCII character 0x30..0x39
//               dout_valid  - dout qualifier, held until dout_ready
//               dout_ready  - downstream accepts dout on valid&ready
//               dout_last   - high with the final (least significant) char
//               overflow    - one-cycle pulse when accepted din >= 10**DIGITS
// Revision    : 1.0 - initial release
// ============================================================================
module bin2ascii #(
    parameter int DIGITS    = 3,
    parameter int LEAD_ZERO = 1,
    localparam int W        = $clog2(10**DIGITS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [7:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         overflow
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_W = $clog2(W + 1);

    localparam logic [W-1:0]       c_LIMIT    = W'(10**DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MSD  = c_IDX_W'(DIGITS - 1);
    localparam logic [7:0]         c_ASCII_0  = 8'h30;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [W-1:0]       r_bin;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_dout;
    logic               r_dout_valid;
    logic               r_dout_last;
    logic               r_din_ready;
    logic               r_overflow;

    // ------------------------------------------------------------------------
    // Next-state values and helpers
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_next;
    logic [W-1:0]       w_bin_next;
    logic [c_BCD_W-1:0] w_bcd_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_IDX_W-1:0] w_idx_next;
    logic [7:0]         w_dout_next;
    logic               w_dout_valid_next;
    logic               w_dout_last_next;
    logic               w_din_ready_next;
    logic               w_overflow_next;

    logic               w_din_over;
    logic [W-1:0]       w_din_sat;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [c_BCD_W-1:0] w_bcd_step;
    logic [c_IDX_W-1:0] w_first_idx;
    logic [c_IDX_W-1:0] w_idx_dec;
    logic [3:0]         w_digit_first;
    logic [3:0]         w_digit_dec;

    // Out-of-range inputs saturate to the all-nines value.
    assign w_din_over = (din >= c_LIMIT);
    assign w_din_sat  = w_din_over ? (c_LIMIT - W'(1)) : din;

    // Double-dabble step: correct every BCD digit >= 5 by +3, then shift the
    // whole BCD register left pulling in the next binary MSB. The top bit of
    // the corrected value is dropped by the width cast; it is always zero for
    // in-range values.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_step = c_BCD_W'({w_bcd_adj, r_bin[W-1]});

    // Index of the first digit to present once conversion is complete.
    generate
        if (LEAD_ZERO != 0) begin : g_lead_zero
            assign w_first_idx = c_IDX_MSD;
        end else begin : g_skip_zero
            // Highest non-zero digit; digit 0 is always emitted so a zero
            // value still produces a single '0'.
            always_comb begin
                w_first_idx = '0;
                for (int i = 1; i < DIGITS; i++) begin
                    if (r_bcd[4*i +: 4] != 4'd0) begin
                        w_first_idx = c_IDX_W'(i);
                    end
                end
            end
        end
    endgenerate

    assign w_idx_dec     = r_idx - c_IDX_W'(1);
    assign w_digit_first = r_bcd[{w_first_idx, 2'b00} +: 4];
    assign w_digit_dec   = r_bcd[{w_idx_dec, 2'b00} +: 4];

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_bin_next        = r_bin;
        w_bcd_next        = r_bcd;
        w_cnt_next        = r_cnt;
        w_idx_next        = r_idx;
        w_dout_next       = r_dout;
        w_dout_valid_next = r_dout_valid;
        w_dout_last_next  = r_dout_last;
        w_din_ready_next  = r_din_ready;
        w_overflow_next   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // din_ready rises one edge after reset release, then stays up
                // until a value is taken.
                w_din_ready_next = 1'b1;
                if (din_valid && r_din_ready) begin
                    w_din_ready_next = 1'b0;
                    w_bin_next       = w_din_sat;
                    w_bcd_next       = '0;
                    w_cnt_next       = '0;
                    w_overflow_next  = w_din_over;
                    w_state_next     = c_ST_CONV;
                end
            end

            c_ST_CONV: begin
                // Fixed W steps regardless of value.
                w_bin_next = {r_bin[W-2:0], 1'b0};
                w_bcd_next = w_bcd_step;
                w_cnt_next = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_ST_SEND;
                end
            end

            c_ST_SEND: begin
                if (!r_dout_valid) begin
                    // First character of the value.
                    w_idx_next        = w_first_idx;
                    w_dout_next       = c_ASCII_0 + {4'h0, w_digit_first};
                    w_dout_last_next  = (w_first_idx == '0);
                    w_dout_valid_next = 1'b1;
                end else if (dout_ready) begin
                    if (r_dout_last) begin
                        w_dout_valid_next = 1'b0;
                        w_dout_last_next  = 1'b0;
                        w_din_ready_next  = 1'b1;
                        w_state_next      = c_ST_IDLE;
                    end else begin
                        // Next digit presented immediately, no bubble.
                        w_idx_next       = w_idx_dec;
                        w_dout_next      = c_ASCII_0 + {4'h0, w_digit_dec};
                        w_dout_last_next = (w_idx_dec == '0);
                    end
                end
            end

            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_din_ready  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bin        <= w_bin_next;
            r_bcd        <= w_bcd_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_dout_valid_next;
            r_dout_last  <= w_dout_last_next;
            r_din_ready  <= w_din_ready_next;
            r_overflow   <= w_overflow_next;
        end
    end

    assign din_ready  = r_din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2ascii.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2ascii
// Description : Self-checking bench for bin2ascii. Three instances cover
//               DIGITS=3/LEAD_ZERO=1, DIGITS=3/LEAD_ZERO=0 and
//               DIGITS=2/LEAD_ZERO=1. A decimal-arithmetic model predicts the
//               character stream, latency, overflow pulse and ready behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2ascii;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] din        [3];
    logic       din_valid  [3];
    logic       dout_ready [3];
    logic       din_ready  [3];
    logic [7:0] dout       [3];
    logic       dout_valid [3];
    logic       dout_last  [3];
    logic       overflow   [3];

    int n_checks = 0;
    int n_fail   = 0;

    bit rdy_manual [3];
    bit rdy_rand = 1'b0;

    // Model state
    bit          busy      [3];
    bit          started   [3];
    bit          ovf_exp   [3];
    bit          after_rst [3];
    int          cnt       [3];
    int          pos       [3];
    int          exp_n     [3];
    int          lat       [3];
    int          done_cnt  [3];
    int          ovf_cycles[3];
    int          obs_n     [3];
    int          obs_len   [3];
    logic [31:0] exp_str   [3];
    logic [31:0] obs_buf   [3];
    logic [31:0] obs_val   [3];

    always #5 clk = ~clk;

    bin2ascii #(.DIGITS(3), .LEAD_ZERO(1)) u_d3_lz (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
        .dout_ready(dout_ready[0]), .dout_last(dout_last[0]), .overflow(overflow[0])
    );

    bin2ascii #(.DIGITS(3), .LEAD_ZERO(0)) u_d3_nz (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
        .dout_ready(dout_ready[1]), .dout_last(dout_last[1]), .overflow(overflow[1])
    );

    bin2ascii #(.DIGITS(2), .LEAD_ZERO(1)) u_d2_lz (
        .clk(clk), .rst_n(rst_n), .din(din[2][6:0]), .din_valid(din_valid[2]),
        .din_ready(din_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
        .dout_ready(dout_ready[2]), .dout_last(dout_last[2]), .overflow(overflow[2])
    );

    function automatic int f_digits(input int k);
        return (k == 2) ? 2 : 3;
    endfunction

    function automatic int f_lz(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int f_w(input int k);
        return (k == 2) ? 7 : 10;
    endfunction

    function automatic int pow10(input int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    // Expected characters packed oldest-first into the high bytes.
    function automatic logic [31:0] model_str(input int d, input int lz, input int v,
                                              output int n);
        int s;
        int dg;
        logic [31:0] r;
        r = 32'h0;
        n = 0;
        s = (v >= pow10(d)) ? pow10(d) - 1 : v;
        for (int p = d - 1; p >= 0; p--) begin
            dg = (s / pow10(p)) % 10;
            if (lz == 0 && n == 0 && dg == 0 && p != 0) continue;
            r = {r[23:0], 8'h30 + 8'(dg)};
            n++;
        end
        return r;
    endfunction

    task automatic chk_eq(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Compare process: evaluated each falling edge, predicts the next rise.
    // ------------------------------------------------------------------------
    initial begin
        int v;
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0; started[k] = 0; ovf_exp[k] = 0; after_rst[k] = 1;
            cnt[k] = 0; pos[k] = 0; exp_n[k] = 0; lat[k] = 0; done_cnt[k] = 0;
            ovf_cycles[k] = 0; obs_n[k] = 0; obs_len[k] = 0;
            exp_str[k] = 0; obs_buf[k] = 0; obs_val[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    chk_eq("rst_din_ready", din_ready[k], 0);
                    chk_eq("rst_dout_valid", dout_valid[k], 0);
                    chk_eq("rst_dout", dout[k], 0);
                    chk_eq("rst_dout_last", dout_last[k], 0);
                    chk_eq("rst_overflow", overflow[k], 0);
                    busy[k] = 0; started[k] = 0; ovf_exp[k] = 0; after_rst[k] = 1;
                    obs_n[k] = 0; obs_buf[k] = 0;
                end else begin
                    chk_eq("din_ready", din_ready[k], (!busy[k] && !after_rst[k]) ? 1 : 0);
                    chk_eq("overflow", overflow[k], ovf_exp[k]);
                    if (overflow[k]) ovf_cycles[k]++;
                    ovf_exp[k] = 0;
                    if (!busy[k]) begin
                        chk_eq("idle_dout_valid", dout_valid[k], 0);
                        if (din_valid[k] && !after_rst[k]) begin
                            v = int'(din[k]) & ((1 << f_w(k)) - 1);
                            exp_str[k] = model_str(f_digits(k), f_lz(k), v, exp_n[k]);
                            ovf_exp[k] = (v >= pow10(f_digits(k)));
                            busy[k] = 1; started[k] = 0; cnt[k] = 0; pos[k] = 0;
                        end
                    end else begin
                        if (!started[k]) begin
                            if (dout_valid[k]) begin
                                chk_eq("early_valid", (cnt[k] >= f_w(k) + 1) ? 1 : 0, 1);
                                if (f_lz(k) != 0) chk_eq("first_latency", cnt[k], f_w(k) + 1);
                                started[k] = 1;
                                lat[k] = cnt[k];
                            end else if (cnt[k] >= ((f_lz(k) != 0) ? f_w(k) + 1
                                                                  : f_w(k) + f_digits(k))) begin
                                chk_eq("valid_timeout", 0, 1);
                                busy[k] = 0;
                            end
                        end
                        if (started[k]) begin
                            chk_eq("dout_valid_held", dout_valid[k], 1);
                            chk_eq("dout", dout[k], exp_str[k][8*(exp_n[k]-1-pos[k]) +: 8]);
                            chk_eq("dout_last", dout_last[k], (pos[k] == exp_n[k] - 1) ? 1 : 0);
                            if (dout_valid[k] && dout_ready[k]) begin
                                obs_buf[k] = {obs_buf[k][23:0], dout[k]};
                                obs_n[k]++;
                                pos[k]++;
                                if (pos[k] >= exp_n[k]) begin
                                    busy[k] = 0; started[k] = 0;
                                    obs_val[k] = obs_buf[k]; obs_len[k] = obs_n[k];
                                    obs_buf[k] = 0; obs_n[k] = 0;
                                    done_cnt[k]++;
                                end
                            end
                        end
                        cnt[k]++;
                    end
                    after_rst[k] = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rdy_manual[k]) dout_ready[k] = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input int k, input int v);
        bit ok = 0;
        din[k] = 10'(v);
        din_valid[k] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready[k]) begin ok = 1; break; end
        end
        if (!ok) chk_eq("accept_timeout", 0, 1);
        tick();
        din_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int c0);
        for (int i = 0; i < 300 && done_cnt[k] == c0; i++) tick();
        chk_eq("value_done", done_cnt[k], c0 + 1);
    endtask

    task automatic run(input int k, input int v, input logic [31:0] req, input int n);
        int c0;
        c0 = done_cnt[k];
        send(k, v);
        wait_done(k, c0);
        chk_eq("stream", obs_val[k], req);
        chk_eq("stream_len", obs_len[k], n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int c0;
        int o0;
        int k;
        int v;
        logic [31:0] m;
        bit ok;

        for (int i = 0; i < 3; i++) begin
            din[i] = '0; din_valid[i] = 1'b0; dout_ready[i] = 1'b1; rdy_manual[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_eq("ready_after_release", din_ready[0], 1);

        // Hand-computed values pinning the model
        m = model_str(3, 1, 7, n);    chk_eq("model_007", m, 32'h303037); chk_eq("model_007_n", n, 3);
        m = model_str(3, 0, 120, n);  chk_eq("model_120", m, 32'h313230);
        m = model_str(3, 0, 0, n);    chk_eq("model_0", m, 32'h30);       chk_eq("model_0_n", n, 1);
        m = model_str(3, 1, 1000, n); chk_eq("model_sat", m, 32'h393939);
        m = model_str(2, 1, 59, n);   chk_eq("model_59", m, 32'h3539);

        // Directed cases
        run(0, 7, 32'h303037, 3);
        chk_eq("latency_d3", lat[0], 11);
        run(1, 7, 32'h37, 1);
        run(1, 0, 32'h30, 1);
        run(1, 120, 32'h313230, 3);
        o0 = ovf_cycles[0];
        run(0, 1000, 32'h393939, 3);
        chk_eq("overflow_pulse_cycles", ovf_cycles[0] - o0, 1);

        // Stall on the second char of 59, with an ignored din pulse of 42
        rdy_manual[2] = 1'b1;
        dout_ready[2] = 1'b1;
        c0 = done_cnt[2];
        send(2, 59);
        for (int i = 0; i < 60 && obs_n[2] != 1; i++) tick();
        dout_ready[2] = 1'b0;
        din[2] = 10'd42;
        din_valid[2] = 1'b1;
        tick();
        din_valid[2] = 1'b0;
        repeat (4) tick();
        dout_ready[2] = 1'b1;
        wait_done(2, c0);
        chk_eq("stall_stream", obs_val[2], 32'h3539);
        repeat (10) tick();
        chk_eq("ignored_din", done_cnt[2], c0 + 1);
        rdy_manual[2] = 1'b0;

        // Reset in the middle of sending 123, after the '1' has gone out
        rdy_manual[0] = 1'b1;
        dout_ready[0] = 1'b0;
        c0 = done_cnt[0];
        send(0, 123);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dout_valid[0]) begin ok = 1; break; end
        end
        chk_eq("abort_setup", ok, 1);
        dout_ready[0] = 1'b1;
        tick();
        dout_ready[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_valid", dout_valid[0], 0);
        tick();
        tick();
        rst_n = 1'b1;
        rdy_manual[0] = 1'b0;
        repeat (3) tick();
        chk_eq("abort_no_done", done_cnt[0], c0);
        run(0, 45, 32'h303435, 3);

        // Randomized values and backpressure
        rdy_rand = 1'b1;
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 15);
            else v = $urandom_range(0, (1 << f_w(k)) - 1);
            m = model_str(f_digits(k), f_lz(k), v, n);
            run(k, v, m, n);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
